// File: rtl/mcdt_pkg.sv
// Shared types and constants for the MCDT channel arbiter.
package mcdt_pkg;

  localparam int NUM_CH  = 3;
  localparam int BURST_W = 3;

  typedef logic [1:0] ch_id_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Channel that follows c in round-robin order (2 wraps to 0).
  function automatic ch_id_t next_ch(input ch_id_t c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

endpackage

// File: rtl/mcdt_arbiter_if.sv
// Channel FIFO heads/pops and the registered formatter-facing output bus.
interface mcdt_arbiter_if #(parameter int DW = 32);
  import mcdt_pkg::*;

  logic [DW-1:0] ch0_data_i;
  logic [DW-1:0] ch1_data_i;
  logic [DW-1:0] ch2_data_i;
  logic          ch0_req_i;
  logic          ch1_req_i;
  logic          ch2_req_i;
  logic          ch0_pop_o;
  logic          ch1_pop_o;
  logic          ch2_pop_o;
  logic [DW-1:0] mcdt_data_o;
  logic          mcdt_val_o;
  ch_id_t        mcdt_id_o;
  logic          arb_busy_o;

  modport slave (
    input  ch0_data_i, ch1_data_i, ch2_data_i,
    input  ch0_req_i, ch1_req_i, ch2_req_i,
    output ch0_pop_o, ch1_pop_o, ch2_pop_o,
    output mcdt_data_o, mcdt_val_o, mcdt_id_o, arb_busy_o
  );

  modport master (
    output ch0_data_i, ch1_data_i, ch2_data_i,
    output ch0_req_i, ch1_req_i, ch2_req_i,
    input  ch0_pop_o, ch1_pop_o, ch2_pop_o,
    input  mcdt_data_o, mcdt_val_o, mcdt_id_o, arb_busy_o
  );

endinterface

// File: rtl/mcdt_rr_pick.sv
// Round-robin pick: first eligible channel scanning ptr, ptr+1, ptr+2 (mod 3).
module mcdt_rr_pick
  import mcdt_pkg::*;
(
  input  logic [NUM_CH-1:0] elig,
  input  ch_id_t            ptr,
  output ch_id_t            pick,
  output logic              any
);

  ch_id_t c;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    c    = (ptr > 2'd2) ? 2'd0 : ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any && elig[c]) begin
        pick = c;
        any  = 1'b1;
      end
      c = next_ch(c);
    end
  end

endmodule

// File: rtl/mcdt_arbiter.sv
// Round-robin burst arbiter popping three show-ahead channel FIFOs onto the MCDT bus.
//   state    | meaning
//   ARB_IDLE | arbitrate; latch grant and burst length when any channel is eligible
//   ARB_BUSY | pop granted channel each cycle until burst complete or it stops being eligible
module mcdt_arbiter
  import mcdt_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NUM_CH-1:0]  ch_en_i,
  input  logic [BURST_W-1:0] burst_len_i,
  mcdt_arbiter_if.slave      bus
);

  arb_state_e         state, state_nxt;
  ch_id_t             ptr, gnt, pick;
  logic               any;
  logic [BURST_W-1:0] cnt, blen;
  logic [NUM_CH-1:0]  req, elig, pop;
  logic               grant, done, pop_any;
  logic [DW-1:0]      gnt_data;

  assign req  = {bus.ch2_req_i, bus.ch1_req_i, bus.ch0_req_i};
  assign elig = req & ch_en_i;

  mcdt_rr_pick u_pick (
    .elig (elig),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  // Pops are decoded from state so reset kills them without waiting for an edge.
  always_comb begin
    state_nxt = state;
    pop       = '0;
    grant     = 1'b0;
    done      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any) begin
          grant     = 1'b1;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        pop[gnt] = elig[gnt];
        if (!elig[gnt] || (cnt == blen)) begin
          done      = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign pop_any = |pop;

  always_comb begin
    gnt_data = '0;
    case (gnt)
      2'd0:    gnt_data = bus.ch0_data_i;
      2'd1:    gnt_data = bus.ch1_data_i;
      2'd2:    gnt_data = bus.ch2_data_i;
      default: gnt_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr             <= '0;
      gnt             <= '0;
      cnt             <= '0;
      blen            <= '0;
      bus.mcdt_data_o <= '0;
      bus.mcdt_val_o  <= 1'b0;
      bus.mcdt_id_o   <= '0;
    end else begin
      if (grant) begin
        gnt  <= pick;
        blen <= burst_len_i;
        cnt  <= '0;
      end
      if (pop_any) cnt <= cnt + 1'b1;
      if (done)    ptr <= next_ch(gnt);
      bus.mcdt_val_o <= pop_any;
      if (pop_any) begin
        bus.mcdt_data_o <= gnt_data;
        bus.mcdt_id_o   <= gnt;
      end
    end
  end

  assign bus.ch0_pop_o  = pop[0];
  assign bus.ch1_pop_o  = pop[1];
  assign bus.ch2_pop_o  = pop[2];
  assign bus.arb_busy_o = (state == ARB_BUSY);

endmodule
